// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared ALU and a single memory port, with an ack-timeout watchdog.
module multicycle_control #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] Op_i,
    input  logic       MemAck_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       PCSource_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [1:0] ALUOp_o,
    output logic       InstrDone_o,
    output logic       Illegal_o,
    output logic       Timeout_o,
    output logic [2:0] State_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    // Timeout fires in the wait cycle that would bring the counter to the limit.
    localparam logic [7:0] LIMIT_M1 = 8'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [7:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic waiting;
    logic expired;
    logic legal_op;

    assign waiting  = (state_q == FETCH) || (state_q == MEM);
    assign expired  = (ACK_TIMEOUT != 0) && waiting && !MemAck_i && (cnt_q == LIMIT_M1);
    assign legal_op = (Op_i == OP_R) || (Op_i == OP_ADDI) || (Op_i == OP_LW) ||
                      (Op_i == OP_SW) || (Op_i == OP_BEQ);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        illegal_d     = illegal_q;
        timeout_d     = timeout_q;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        PCSource_o    = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        RegDst_o      = 1'b0;
        MemtoReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 2'b00;
        InstrDone_o   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = FETCH;
            end
            FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = MemAck_i;
                PCWrite_o = MemAck_i;
                if (MemAck_i) state_d = DECODE;
            end
            DECODE: begin
                op_d      = Op_i;
                ALUSrcB_o = 2'b11;
                if (legal_op) begin
                    state_d = EXEC;
                end else begin
                    illegal_d   = 1'b1;
                    InstrDone_o = 1'b1;
                    state_d     = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA_o = 1'b1;
                if (op_q == OP_R) begin
                    ALUOp_o = 2'b10;
                    state_d = WB;
                end else if (op_q == OP_BEQ) begin
                    ALUOp_o       = 2'b01;
                    PCWriteCond_o = 1'b1;
                    PCSource_o    = 1'b1;
                    InstrDone_o   = 1'b1;
                    state_d       = FETCH;
                end else begin
                    ALUSrcB_o = 2'b10;
                    state_d   = (op_q == OP_ADDI) ? WB : MEM;
                end
            end
            MEM: begin
                IorD_o = 1'b1;
                if (op_q == OP_LW) begin
                    MemRead_o = 1'b1;
                    if (MemAck_i) state_d = WB;
                end else begin
                    MemWrite_o  = 1'b1;
                    InstrDone_o = MemAck_i;
                    if (MemAck_i) state_d = FETCH;
                end
            end
            WB: begin
                RegWrite_o  = 1'b1;
                InstrDone_o = 1'b1;
                RegDst_o    = (op_q == OP_R);
                MemtoReg_o  = (op_q == OP_LW);
                state_d     = FETCH;
            end
            default: state_d = IDLE;
        endcase

        if (expired) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
        end
    end

    // Wait counter restarts whenever FETCH or MEM is freshly entered.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && !MemAck_i && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign Illegal_o = illegal_q;
    assign Timeout_o = timeout_q;
    assign State_o   = state_q;

endmodule
